writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  - Write-side master of the 32-entry register file.
//  - Merges single-cycle ALU results and variable-latency load results onto the one regfile
//    write port (regwrite / rd / write_data).
//  - Load results are queued in a small FIFO; ALU has priority, bounded by an anti-starvation counter.
//  - Exports a pending-destination mask so the hazard unit can stall readers of queued registers.
// PARAMETERS
//  WIDTH     32  data width of regfile entries and result buses
//  DEPTH     4   load-result FIFO entries (power of two, >=2)
//  MAX_WAIT  3   consecutive cycles a non-empty FIFO head may lose to ALU before it is forced out
// PORTS
//  clk             in   1      single clock; all state updates on rising edge
//  reset           in   1      synchronous, active-high reset
//  i_alu_valid     in   1      ALU result present this cycle
//  i_alu_rd        in   5      ALU destination register
//  i_alu_data      in   WIDTH  ALU result
//  o_alu_stall     out  1      ALU result NOT consumed this cycle; upstream holds valid/rd/data stable
//  i_ld_valid      in   1      load result offered
//  o_ld_ready      out  1      FIFO can accept; transfer when i_ld_valid && o_ld_ready at edge
//  i_ld_rd         in   5      load destination register
//  i_ld_data       in   WIDTH  load data
//  o_regwrite      out  1      regfile write enable (registered)
//  o_rd            out  5      regfile write address (registered)
//  o_write_data    out  WIDTH  regfile write data (registered)
//  o_pending_mask  out  32     bit r set iff some queued FIFO entry targets xr (bit 0 always 0)
// BEHAVIOUR
//  - Reset, synchronous, active-high, applied at any time:
//    - o_regwrite=0, o_rd=0, o_write_data=0; FIFO emptied; wait counter=0.
//    - Queued entries are discarded, no write issued.
//    - o_ld_ready=0 while reset is high, 1 the cycle after.
//  - ALU source: effective valid = i_alu_valid && i_alu_rd!=0. A valid with rd=0 is consumed and
//    dropped without a write, and does not block the FIFO.
//  - Arbitration each cycle, combinational from registered state; at most one winner:
//    - force = fifo_not_empty && wait_cnt==MAX_WAIT.
//    - If force: FIFO head wins and o_alu_stall = i_alu_valid && i_alu_rd!=0.
//    - Else if ALU effective valid: ALU wins and o_alu_stall=0.
//    - Else if FIFO not empty: FIFO head wins.
//    - Else: no write.
//  - Winner is registered into o_regwrite/o_rd/o_write_data at the edge. ALU latency: 1 cycle.
//  - Loads: push at edge N; earliest write visible after edge N+1 (latency 2); no FIFO bypass path.
//  - Load entries with rd=0 are accepted, queued and popped in order but produce o_regwrite=0.
//  - wait_cnt: clears on FIFO pop or when FIFO empty; otherwise increments while head loses;
//    saturates at MAX_WAIT. Width $clog2(MAX_WAIT+1).
//  - FIFO:
//    - o_ld_ready = !full, derived from registered count only; push when full is impossible.
//    - Push and pop in the same cycle are allowed at any occupancy except push-when-full.
//    - Strict in-order pops; pointers wrap modulo DEPTH.
//  - o_pending_mask: OR of one-hot(rd) over valid entries, bit 0 masked.
//    - Reflects registered FIFO state, so an entry popped at edge N clears its bit after edge N.
//  - WAW: ALU write to an rd present in o_pending_mask is the hazard unit's responsibility to
//    stall; this block does not reorder.
//  - o_regwrite is never asserted with o_rd=0.
// STRUCTURE
//  - Shared package: REG_ADDR_W=5, NUM_REGS=32, entry struct {rd[4:0], data[WIDTH-1:0]}.
//  - Sub-module wb_fifo: synchronous FIFO (DEPTH x entry) with full/empty/count and an entry
//    valid vector exposed for mask generation.
//  - Top level holds arbitration, wait counter and output registers.
// TESTING
//  1 Reset: hold reset 3 cycles with i_ld_valid=1 -> o_regwrite=0, o_ld_ready=0 during reset,
//    1 after; mask=0.
//  2 ALU write: alu_valid, rd=5, data=32'hDEADBEEF at edge N -> after N: o_regwrite=1, o_rd=5,
//    o_write_data=32'hDEADBEEF.
//  3 Starvation, MAX_WAIT=3: ALU valid every cycle rd=1; one load rd=7, data=32'h1234 ->
//    mask[7]=1; head loses 3 cycles; 4th cycle o_alu_stall=1; write rd=7 data 32'h1234; mask[7]
//    clears; ALU write follows next cycle.
//  4 Full: ALU busy, loads rd=8..12 offered -> o_ld_ready=0 after 4 accepts; rd=12 held; drain order
//    8,9,10,11,12.
//  5 rd=0: ALU valid rd=0 with FIFO holding rd=3 -> no ALU write; rd=3 written the next cycle,
//    o_alu_stall=0.
//  6 Mid-op reset with 2 queued entries -> no writes issued; mask=0; wait_cnt=0; next load starts
//    from an empty FIFO.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// ============================================================================
//  Module      : writeback_arbiter_pkg
//  Description : Shared register-file constants and helpers for the writeback path.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package writeback_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is hardwired, so it never appears as a pending destination.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input reg_addr_t rd);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (rd != '0) begin
            v[rd] = 1'b1;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_arbiter_wb_fifo.sv
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous load-result FIFO exposing per-slot valid bits and rd fields.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = REG_ADDR_W + 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_push,
    input  logic [ENTRY_W-1:0]                 i_push_entry,
    input  logic                               i_pop,
    output logic [ENTRY_W-1:0]                 o_head,
    output logic                               o_full,
    output logic                               o_empty,
    output logic [DEPTH-1:0]                   o_entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   o_entry_rd
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DEPTH-1:0][ENTRY_W-1:0] r_mem;
    logic [c_ptr_w-1:0]            r_wr_ptr;
    logic [c_ptr_w-1:0]            r_rd_ptr;
    logic [c_cnt_w-1:0]            r_count;
    logic                          w_push;
    logic                          w_pop;

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [c_ptr_w-1:0] w_offset;
        assign w_offset         = c_ptr_w'(g) - r_rd_ptr;
        assign o_entry_valid[g] = ({1'b0, w_offset} < r_count);
        assign o_entry_rd[g]    = r_mem[g][ENTRY_W-1 -: REG_ADDR_W];
    end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Merges ALU and queued load results onto the single regfile write port.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [WIDTH-1:0]      i_alu_data,
    output logic                  o_alu_stall,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [WIDTH-1:0]      i_ld_data,
    output logic                  o_regwrite,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [WIDTH-1:0]      o_write_data,
    output logic [NUM_REGS-1:0]   o_pending_mask
);

    typedef struct packed {
        reg_addr_t        rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam int                c_wait_w   = $clog2(MAX_WAIT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MAX_WAIT);

    entry_t                         w_head;
    entry_t                         w_push_entry;
    logic                           w_full;
    logic                           w_empty;
    logic [DEPTH-1:0]               w_entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_entry_rd;
    logic                           w_alu_eff;
    logic                           w_force;
    logic                           w_alu_win;
    logic                           w_pop;
    logic                           w_push;
    logic [NUM_REGS-1:0]            w_mask;

    logic [c_wait_w-1:0]            r_wait_cnt;
    logic                           r_regwrite;
    reg_addr_t                      r_rd;
    logic [WIDTH-1:0]               r_write_data;

    assign w_push_entry = '{rd: i_ld_rd, data: i_ld_data};
    assign o_ld_ready   = !reset && !w_full;
    assign w_push       = i_ld_valid && o_ld_ready;

    wb_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W ($bits(entry_t))
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_pop         (w_pop),
        .o_head        (w_head),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_entry_valid (w_entry_valid),
        .o_entry_rd    (w_entry_rd)
    );

    // An ALU result aimed at x0 is swallowed here and never competes for the port.
    assign w_alu_eff   = i_alu_valid && (i_alu_rd != '0);
    assign w_force     = !w_empty && (r_wait_cnt == c_wait_max);
    assign w_alu_win   = !w_force && w_alu_eff;
    assign w_pop       = w_force || (!w_alu_eff && !w_empty);
    assign o_alu_stall = w_force && w_alu_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt   <= '0;
            r_regwrite   <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
        end else begin
            if (w_empty || w_pop) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_wait_max) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_alu_win) begin
                r_regwrite   <= 1'b1;
                r_rd         <= i_alu_rd;
                r_write_data <= i_alu_data;
            end else if (w_pop) begin
                r_regwrite   <= (w_head.rd != '0);
                r_rd         <= w_head.rd;
                r_write_data <= w_head.data;
            end else begin
                r_regwrite   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                w_mask = w_mask | rd_onehot(w_entry_rd[i]);
            end
        end
    end

    assign o_regwrite     = r_regwrite;
    assign o_rd           = r_rd;
    assign o_write_data   = r_write_data;
    assign o_pending_mask = w_mask;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
//  Module      : tb_writeback_arbiter
//  Description : Directed self-checking bench for writeback_arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.WIDTH(32), .DEPTH(4), .MAX_WAIT(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_alu_valid    (alu_valid),
        .i_alu_rd       (alu_rd),
        .i_alu_data     (alu_data),
        .o_alu_stall    (alu_stall),
        .i_ld_valid     (ld_valid),
        .o_ld_ready     (ld_ready),
        .i_ld_rd        (ld_rd),
        .i_ld_data      (ld_data),
        .o_regwrite     (regwrite),
        .o_rd           (rd),
        .o_write_data   (write_data),
        .o_pending_mask (pending_mask)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
        repeat (3) begin
            tick;
            n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %b want 0", regwrite); end
            n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
            n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", pending_mask); end
        end
        reset = 1'b0; ld_valid = 1'b0;
        #1;
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ld_ready got %b want 1", ld_ready); end
        tick;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL post_reset_regwrite got %b want 0", regwrite); end
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL post_reset_mask got %h want 0", pending_mask); end
    endtask

    task automatic test_alu_write;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", alu_stall); end
        tick;
        alu_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite got %b want 1", regwrite); end
        n_checks++; if (rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd got %0d want 5", rd); end
        n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data got %h want deadbeef", write_data); end
        tick;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL alu_idle_regwrite got %b want 0", regwrite); end
    endtask

    task automatic test_starvation;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0000001;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234;
        tick;
        ld_valid = 1'b0;
        n_checks++; if (pending_mask !== 32'h80) begin n_fail++; $display("FAIL starve_mask_set got %h want 00000080", pending_mask); end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_lose%0d_stall got %b want 0", i, alu_stall); end
            tick;
            n_checks++; if (regwrite !== 1'b1 || rd !== 5'd1) begin n_fail++; $display("FAIL starve_lose%0d_write got we=%b rd=%0d want we=1 rd=1", i, regwrite, rd); end
            n_checks++; if (pending_mask !== 32'h80) begin n_fail++; $display("FAIL starve_lose%0d_mask got %h want 00000080", i, pending_mask); end
        end
        #1;
        n_checks++; if (alu_stall !== 1'b1) begin n_fail++; $display("FAIL starve_force_stall got %b want 1", alu_stall); end
        tick;
        n_checks++; if (regwrite !== 1'b1 || rd !== 5'd7 || write_data !== 32'h1234) begin n_fail++; $display("FAIL starve_load_write got we=%b rd=%0d data=%h want we=1 rd=7 data=00001234", regwrite, rd, write_data); end
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL starve_mask_clear got %h want 0", pending_mask); end
        n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release_stall got %b want 0", alu_stall); end
        tick;
        alu_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b1 || rd !== 5'd1 || write_data !== 32'hA0000001) begin n_fail++; $display("FAIL starve_alu_follow got we=%b rd=%0d data=%h want we=1 rd=1 data=a0000001", regwrite, rd, write_data); end
        tick;
    endtask

    task automatic test_full;
        int k = 8;
        int accepted = 0;
        bit saw_block = 1'b0;
        bit acc;
        logic [4:0]  got_rd[$];
        logic [31:0] got_data[$];
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
        for (int cyc = 0; cyc < 40; cyc++) begin
            ld_valid = (k <= 12);
            ld_rd    = 5'(k);
            ld_data  = 32'h100 + 32'(k);
            #1;
            acc = ld_valid && ld_ready;
            if (k == 12 && accepted == 4 && !saw_block) begin
                saw_block = 1'b1;
                n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ld_ready got %b want 0", ld_ready); end
            end
            tick;
            if (acc) begin k++; accepted++; end
            if (regwrite === 1'b1 && rd !== 5'd1) begin
                got_rd.push_back(rd);
                got_data.push_back(write_data);
            end
        end
        ld_valid = 1'b0; alu_valid = 1'b0;
        n_checks++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL full_block_seen got %b want 1", saw_block); end
        n_checks++; if (got_rd.size() != 5) begin n_fail++; $display("FAIL full_drain_count got %0d want 5", got_rd.size()); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got_rd.size()) begin
                n_fail++; $display("FAIL full_drain%0d got none want rd=%0d", i, 8 + i);
            end else if (got_rd[i] !== 5'(8 + i) || got_data[i] !== 32'h108 + 32'(i)) begin
                n_fail++; $display("FAIL full_drain%0d got rd=%0d data=%h want rd=%0d data=%h", i, got_rd[i], got_data[i], 8 + i, 32'h108 + 32'(i));
            end
        end
        tick;
    endtask

    task automatic test_rd_zero;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33;
        tick;
        ld_valid = 1'b0;
        n_checks++; if (pending_mask !== 32'h8) begin n_fail++; $display("FAIL rd0_mask got %h want 00000008", pending_mask); end
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
        #1;
        n_checks++; if (alu_stall !== 1'b0) begin n_fail++; $display("FAIL rd0_stall got %b want 0", alu_stall); end
        tick;
        alu_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b1 || rd !== 5'd3 || write_data !== 32'h33) begin n_fail++; $display("FAIL rd0_load_write got we=%b rd=%0d data=%h want we=1 rd=3 data=00000033", regwrite, rd, write_data); end
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL rd0_mask_clear got %h want 0", pending_mask); end
        // A load aimed at x0 still occupies a slot but never writes.
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
        tick;
        ld_valid = 1'b0;
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL ld_rd0_mask got %h want 0", pending_mask); end
        tick;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL ld_rd0_regwrite got %b want 0", regwrite); end
        tick;
    endtask

    task automatic test_midop_reset;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h77;
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020;
        tick;
        ld_rd = 5'd21; ld_data = 32'h2121;
        tick;
        ld_valid = 1'b0;
        n_checks++; if (pending_mask !== 32'h0030_0000) begin n_fail++; $display("FAIL midrst_mask_before got %h want 00300000", pending_mask); end
        reset = 1'b1;
        tick;
        alu_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_regwrite got %b want 0", regwrite); end
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL midrst_mask got %h want 0", pending_mask); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ld_ready got %b want 0", ld_ready); end
        reset = 1'b0;
        tick;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_no_stale got %b want 0", regwrite); end
        ld_valid = 1'b1; ld_rd = 5'd22; ld_data = 32'h2222;
        tick;
        ld_valid = 1'b0;
        n_checks++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_load_latency got %b want 0", regwrite); end
        tick;
        n_checks++; if (regwrite !== 1'b1 || rd !== 5'd22 || write_data !== 32'h2222) begin n_fail++; $display("FAIL midrst_fresh_load got we=%b rd=%0d data=%h want we=1 rd=22 data=00002222", regwrite, rd, write_data); end
        n_checks++; if (pending_mask !== 32'h0) begin n_fail++; $display("FAIL midrst_final_mask got %h want 0", pending_mask); end
    endtask

    initial begin
        test_reset;
        test_alu_write;
        test_starvation;
        test_full;
        test_rd_zero;
        test_midop_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
